period_sequencer: RTL and testbench
===================================

// Module: period_sequencer
// PURPOSE
//  Central FSM that sequences one level of the symbol-counting game through
//  PRE -> GAME -> ANSWER -> POST -> JUDGE, timing each period in whole seconds.
//  Drives the period one-hots used by display muxing and the start/stop strobes
//  for symbol generation, user counting and scoring. Receives the judge verdict
//  to either advance to the next level or end the game.
// PARAMETERS
//  PRE_SECS     3   seconds in PRE (countdown before play); must be >= 1
//  GAME_SECS    10  seconds in GAME (symbols shown, user counts); must be >= 1
//  ANSWER_SECS  5   seconds in ANSWER (user finalises count); must be >= 1
//  POST_SECS    3   seconds in POST (result shown); must be >= 1
//  CNT_W        8   width of secsLeft; every *_SECS must fit in CNT_W bits
// PORTS
//  Clk100M        in   1      system clock; all logic on rising edge
//  reset          in   1      synchronous, active-high reset
//  tick1Hz        in   1      1-cycle pulse once per second, synchronous to Clk100M
//  start          in   1      begin game; honoured only in IDLE or OVER
//  incLevel       in   1      judge verdict: level passed (sampled only in JUDGE)
//  lose           in   1      judge verdict: level failed (sampled only in JUDGE)
//  pre            out  1      high while in PRE
//  game           out  1      high while in GAME
//  answer         out  1      high while in ANSWER
//  post           out  1      high while in POST
//  startGen       out  1      1-cycle strobe, first cycle of GAME
//  stopGen        out  1      1-cycle strobe, first cycle of ANSWER
//  stopCount      out  1      1-cycle strobe, first cycle of POST
//  levelComplete  out  1      1-cycle strobe, first cycle of JUDGE
//  gameOver       out  1      high while in OVER
//  secsLeft       out  CNT_W  seconds remaining in current timed period
// BEHAVIOUR
//  - States: IDLE, PRE, GAME, ANSWER, POST, JUDGE, OVER. All outputs registered.
//  - Reset: state=IDLE; pre/game/answer/post/gameOver=0; all strobes=0; secsLeft=0.
//  - IDLE/OVER: start=1 -> PRE, secsLeft<=PRE_SECS next cycle. tick1Hz ignored.
//  - Timed states (PRE,GAME,ANSWER,POST): on tick1Hz, if secsLeft==1 move to
//    next state and load its *_SECS; else secsLeft<=secsLeft-1. Without tick,
//    hold. Each timed state therefore spans exactly *_SECS ticks.
//  - Order: PRE->GAME->ANSWER->POST->JUDGE. POST exit loads secsLeft=0.
//  - JUDGE: secsLeft=0; wait indefinitely. lose=1 -> OVER (lose wins if incLevel
//    also 1 same cycle); else incLevel=1 -> PRE with secsLeft=PRE_SECS.
//  - Strobes assert in the same cycle the corresponding one-hot/state first
//    becomes active (registered together), and last exactly one cycle; never
//    reasserted while remaining in that state.
//  - Exactly one of pre/game/answer/post/gameOver high in those states; all
//    low in IDLE and JUDGE.
//  - start outside IDLE/OVER ignored; incLevel/lose outside JUDGE ignored.
//  - start and tick1Hz same cycle in IDLE: start taken, tick not applied to PRE.
//  - reset asserted in any state, mid-period or mid-strobe: next cycle is the
//    reset state; no strobe emitted on the reset edge.
//  - secsLeft never wraps: it is never decremented from 1 or 0.
// TESTING
//  1 reset held 3 cycles in GAME with secsLeft=4 -> IDLE, all outputs 0, secsLeft=0.
//  2 defaults, start then ticks: PRE 3 ticks (secsLeft 3,2,1), then GAME
//    with startGen=1 one cycle and secsLeft=10; after 10 ticks stopGen=1, answer=1.
//  3 full level to JUDGE: levelComplete one cycle; incLevel=1 -> pre=1,
//    secsLeft=3; no strobes while waiting 100 cycles in JUDGE without verdict.
//  4 JUDGE with incLevel=1 and lose=1 same cycle -> OVER, gameOver=1; start ->
//    PRE, secsLeft=3, gameOver=0.
//  5 start and tick1Hz same cycle in IDLE -> pre=1, secsLeft=3 (not 2); start,
//    incLevel, lose pulsed during GAME -> no effect on state or secsLeft.

Source files
------------

// File: rtl/period_sequencer_if.sv
// Control/status bundle between the period sequencer and its neighbours.
// Signalling: there is no valid/ready pairing here. Every input is a level or
// one-cycle pulse sampled on the rising clock edge. Every output is registered.
// Strobes are one-cycle pulses. stateDbg mirrors the sequencer state for
// checkers and debug.
interface period_sequencer_if #(
   parameter int CNT_W = 8
);
   logic             tick1Hz;
   logic             start;
   logic             incLevel;
   logic             lose;
   logic             pre;
   logic             game;
   logic             answer;
   logic             post;
   logic             startGen;
   logic             stopGen;
   logic             stopCount;
   logic             levelComplete;
   logic             gameOver;
   logic [CNT_W-1:0] secsLeft;
   logic [2:0]       stateDbg;

   // Sequencer side
   modport slave (
      input  tick1Hz, start, incLevel, lose,
      output pre, game, answer, post, startGen, stopGen, stopCount,
             levelComplete, gameOver, secsLeft, stateDbg
   );

   // Controller / game-logic side
   modport master (
      output tick1Hz, start, incLevel, lose,
      input  pre, game, answer, post, startGen, stopGen, stopCount,
             levelComplete, gameOver, secsLeft, stateDbg
   );
endinterface

// File: rtl/period_sequencer.sv
// Sequences one game level through PRE -> GAME -> ANSWER -> POST -> JUDGE.
// Each timed period lasts a whole number of 1 Hz ticks. A judge verdict either
// restarts PRE for the next level or ends the game in OVER.
module period_sequencer #(
   parameter int PRE_SECS    = 3,
   parameter int GAME_SECS   = 10,
   parameter int ANSWER_SECS = 5,
   parameter int POST_SECS   = 3,
   parameter int CNT_W       = 8
) (
   input  logic                  Clk100M,
   input  logic                  reset,
   period_sequencer_if.slave     bus
);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      PRE    = 3'd1,
      GAME   = 3'd2,
      ANSWER = 3'd3,
      POST   = 3'd4,
      JUDGE  = 3'd5,
      OVER   = 3'd6
   } state_t;

   localparam logic [CNT_W-1:0] PRE_LD    = CNT_W'(PRE_SECS);
   localparam logic [CNT_W-1:0] GAME_LD   = CNT_W'(GAME_SECS);
   localparam logic [CNT_W-1:0] ANSWER_LD = CNT_W'(ANSWER_SECS);
   localparam logic [CNT_W-1:0] POST_LD   = CNT_W'(POST_SECS);
   localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);

   state_t state;

   assign bus.stateDbg = state;

   // State, seconds counter, period one-hots and entry strobes, all registered together.
   // Each strobe is set only on the transition into its state, so it lasts one cycle.
   // A timed state whose count is 1 or lower advances instead of decrementing,
   // so secsLeft never wraps.
   always_ff @(posedge Clk100M) begin
      if (reset) begin
         state              <= IDLE;
         bus.pre            <= 1'b0;
         bus.game           <= 1'b0;
         bus.answer         <= 1'b0;
         bus.post           <= 1'b0;
         bus.gameOver       <= 1'b0;
         bus.startGen       <= 1'b0;
         bus.stopGen        <= 1'b0;
         bus.stopCount      <= 1'b0;
         bus.levelComplete  <= 1'b0;
         bus.secsLeft       <= '0;
      end else begin
         bus.startGen      <= 1'b0;
         bus.stopGen       <= 1'b0;
         bus.stopCount     <= 1'b0;
         bus.levelComplete <= 1'b0;
         case (state)
            IDLE, OVER: begin
               if (bus.start) begin
                  state        <= PRE;
                  bus.gameOver <= 1'b0;
                  bus.pre      <= 1'b1;
                  bus.secsLeft <= PRE_LD;
               end
            end
            PRE: begin
               if (bus.tick1Hz) begin
                  if (bus.secsLeft <= ONE) begin
                     state        <= GAME;
                     bus.pre      <= 1'b0;
                     bus.game     <= 1'b1;
                     bus.startGen <= 1'b1;
                     bus.secsLeft <= GAME_LD;
                  end else begin
                     bus.secsLeft <= bus.secsLeft - ONE;
                  end
               end
            end
            GAME: begin
               if (bus.tick1Hz) begin
                  if (bus.secsLeft <= ONE) begin
                     state        <= ANSWER;
                     bus.game     <= 1'b0;
                     bus.answer   <= 1'b1;
                     bus.stopGen  <= 1'b1;
                     bus.secsLeft <= ANSWER_LD;
                  end else begin
                     bus.secsLeft <= bus.secsLeft - ONE;
                  end
               end
            end
            ANSWER: begin
               if (bus.tick1Hz) begin
                  if (bus.secsLeft <= ONE) begin
                     state         <= POST;
                     bus.answer    <= 1'b0;
                     bus.post      <= 1'b1;
                     bus.stopCount <= 1'b1;
                     bus.secsLeft  <= POST_LD;
                  end else begin
                     bus.secsLeft <= bus.secsLeft - ONE;
                  end
               end
            end
            POST: begin
               if (bus.tick1Hz) begin
                  if (bus.secsLeft <= ONE) begin
                     state             <= JUDGE;
                     bus.post          <= 1'b0;
                     bus.levelComplete <= 1'b1;
                     bus.secsLeft      <= '0;
                  end else begin
                     bus.secsLeft <= bus.secsLeft - ONE;
                  end
               end
            end
            JUDGE: begin
               // A failed verdict takes priority over a pass in the same cycle.
               if (bus.lose) begin
                  state        <= OVER;
                  bus.gameOver <= 1'b1;
               end else if (bus.incLevel) begin
                  state        <= PRE;
                  bus.pre      <= 1'b1;
                  bus.secsLeft <= PRE_LD;
               end
            end
            default: begin
               state        <= IDLE;
               bus.pre      <= 1'b0;
               bus.game     <= 1'b0;
               bus.answer   <= 1'b0;
               bus.post     <= 1'b0;
               bus.gameOver <= 1'b0;
               bus.secsLeft <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_period_sequencer.sv
// Bench for period_sequencer: directed stimulus, a period-table model feeding an
// expected queue checked every cycle, plus hand-computed literal checks.
module tb_period_sequencer;

   localparam int CNT_W = 8;
   localparam int W     = 9 + CNT_W;

   logic Clk100M;
   logic reset;

   int total;
   int bad;

   period_sequencer_if #(.CNT_W(CNT_W)) bus ();

   period_sequencer #(
      .PRE_SECS(3), .GAME_SECS(10), .ANSWER_SECS(5), .POST_SECS(3), .CNT_W(CNT_W)
   ) dut (
      .Clk100M (Clk100M),
      .reset   (reset),
      .bus     (bus)
   );

   // Clock and reset
   initial Clk100M = 1'b0;
   always #5 Clk100M = ~Clk100M;

   // Scoreboard: model phases 0 idle, 1 pre, 2 game, 3 answer, 4 post, 5 judge, 6 over
   logic [W-1:0] exp_q[$];
   int mPhase;
   int mSecs;
   int periodLen[1:4];
   initial begin
      periodLen[1] = 3;
      periodLen[2] = 10;
      periodLen[3] = 5;
      periodLen[4] = 3;
      mPhase = 0;
      mSecs = 0;
   end

   always @(posedge Clk100M) begin
      int prevPhase;
      logic [8:0] flags;
      prevPhase = mPhase;
      if (reset) begin
         mPhase = 0;
         mSecs = 0;
      end else if (mPhase == 0 || mPhase == 6) begin
         if (bus.start) begin
            mPhase = 1;
            mSecs = periodLen[1];
         end
      end else if (mPhase >= 1 && mPhase <= 4) begin
         if (bus.tick1Hz) begin
            if (mSecs == 1) begin
               mPhase = mPhase + 1;
               mSecs = (mPhase <= 4) ? periodLen[mPhase] : 0;
            end else begin
               mSecs = mSecs - 1;
            end
         end
      end else if (mPhase == 5) begin
         if (bus.lose) mPhase = 6;
         else if (bus.incLevel) begin
            mPhase = 1;
            mSecs = periodLen[1];
         end
      end
      flags[8] = (mPhase == 1);
      flags[7] = (mPhase == 2);
      flags[6] = (mPhase == 3);
      flags[5] = (mPhase == 4);
      flags[4] = !reset && mPhase == 2 && prevPhase != 2;
      flags[3] = !reset && mPhase == 3 && prevPhase != 3;
      flags[2] = !reset && mPhase == 4 && prevPhase != 4;
      flags[1] = !reset && mPhase == 5 && prevPhase != 5;
      flags[0] = (mPhase == 6);
      exp_q.push_back({flags, CNT_W'(mSecs)});
   end

   // Compare process: every cycle, away from the active edge
   always @(negedge Clk100M) begin
      logic [W-1:0] expv;
      logic [W-1:0] got;
      if (exp_q.size() > 0) begin
         expv = exp_q.pop_front();
         got = {bus.pre, bus.game, bus.answer, bus.post, bus.startGen, bus.stopGen,
                bus.stopCount, bus.levelComplete, bus.gameOver, bus.secsLeft};
         total++;
         if (got !== expv) begin
            bad++;
            $display("FAIL cycle_outputs at %0t: got=%h want=%h", $time, got, expv);
         end
      end
   end

   // Driver tasks
   task automatic step(input logic t, input logic s, input logic i,
                       input logic l, input logic r);
      @(negedge Clk100M);
      bus.tick1Hz = t;
      bus.start = s;
      bus.incLevel = i;
      bus.lose = l;
      reset = r;
      @(posedge Clk100M);
      #1;
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) step(0, 0, 0, 0, 0);
   endtask

   // Each tick followed by a quiet cycle so holding is exercised too
   task automatic ticks(input int n);
      for (int k = 0; k < n; k++) begin
         step(1, 0, 0, 0, 0);
         step(0, 0, 0, 0, 0);
      end
   endtask

   task automatic checkVal(input string name, input int act, input int expv);
      total++;
      if (act != expv) begin
         bad++;
         $display("FAIL %s: got=%0d want=%0d", name, act, expv);
      end
   endtask

   // Watchdog
   initial begin
      #200000;
      $display("FAIL watchdog: got=timeout want=finish");
      bad++;
      $display("test done: total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog expired");
   end

   // Stimulus with literal expectations
   initial begin
      total = 0;
      bad = 0;
      bus.tick1Hz = 0;
      bus.start = 0;
      bus.incLevel = 0;
      bus.lose = 0;
      reset = 1;
      step(0, 0, 0, 0, 1);
      step(0, 0, 0, 0, 1);
      checkVal("reset_secs", int'(bus.secsLeft), 0);
      checkVal("reset_pre", int'(bus.pre), 0);

      // Test 1: reset held 3 cycles in GAME with secsLeft=4
      step(0, 1, 0, 0, 0);
      ticks(3);
      checkVal("t1_game", int'(bus.game), 1);
      ticks(6);
      checkVal("t1_secs4", int'(bus.secsLeft), 4);
      step(0, 0, 0, 0, 1);
      step(0, 0, 0, 0, 1);
      step(0, 0, 0, 0, 1);
      checkVal("t1_game_cleared", int'(bus.game), 0);
      checkVal("t1_secs_cleared", int'(bus.secsLeft), 0);

      // Test 2: start, PRE countdown, GAME entry, ANSWER entry
      step(0, 1, 0, 0, 0);
      checkVal("t2_pre", int'(bus.pre), 1);
      checkVal("t2_secs3", int'(bus.secsLeft), 3);
      step(1, 0, 0, 0, 0);
      checkVal("t2_secs2", int'(bus.secsLeft), 2);
      idle(4);
      checkVal("t2_hold2", int'(bus.secsLeft), 2);
      step(1, 0, 0, 0, 0);
      checkVal("t2_secs1", int'(bus.secsLeft), 1);
      step(1, 0, 0, 0, 0);
      checkVal("t2_startGen", int'(bus.startGen), 1);
      checkVal("t2_game_secs10", int'(bus.secsLeft), 10);
      idle(1);
      checkVal("t2_startGen_gone", int'(bus.startGen), 0);
      ticks(9);
      checkVal("t2_game_secs1", int'(bus.secsLeft), 1);
      step(1, 0, 0, 0, 0);
      checkVal("t2_stopGen", int'(bus.stopGen), 1);
      checkVal("t2_answer", int'(bus.answer), 1);
      checkVal("t2_answer_secs5", int'(bus.secsLeft), 5);

      // Test 3: finish the level, wait in JUDGE, advance
      ticks(5);
      checkVal("t3_post", int'(bus.post), 1);
      checkVal("t3_post_secs3", int'(bus.secsLeft), 3);
      ticks(2);
      step(1, 0, 0, 0, 0);
      checkVal("t3_levelComplete", int'(bus.levelComplete), 1);
      checkVal("t3_judge_secs0", int'(bus.secsLeft), 0);
      idle(100);
      checkVal("t3_judge_no_strobe", int'(bus.levelComplete), 0);
      checkVal("t3_judge_post_low", int'(bus.post), 0);
      step(0, 0, 1, 0, 0);
      checkVal("t3_next_pre", int'(bus.pre), 1);
      checkVal("t3_next_secs3", int'(bus.secsLeft), 3);

      // Test 4: run to JUDGE, simultaneous verdicts -> OVER, then restart
      ticks(3 + 10 + 5 + 3);
      checkVal("t4_in_judge_secs", int'(bus.secsLeft), 0);
      step(0, 0, 1, 1, 0);
      checkVal("t4_gameOver", int'(bus.gameOver), 1);
      checkVal("t4_pre_low", int'(bus.pre), 0);
      ticks(2);
      checkVal("t4_over_holds", int'(bus.gameOver), 1);
      step(0, 1, 0, 0, 0);
      checkVal("t4_restart_pre", int'(bus.pre), 1);
      checkVal("t4_restart_secs3", int'(bus.secsLeft), 3);
      checkVal("t4_gameOver_low", int'(bus.gameOver), 0);

      // Test 5: start+tick same cycle in IDLE; stray inputs ignored during play
      step(0, 0, 0, 0, 1);
      step(1, 1, 0, 0, 0);
      checkVal("t5_pre", int'(bus.pre), 1);
      checkVal("t5_secs3_not2", int'(bus.secsLeft), 3);
      step(0, 1, 1, 1, 0);
      checkVal("t5_pre_ignore", int'(bus.secsLeft), 3);
      ticks(3);
      step(0, 1, 0, 0, 0);
      step(0, 0, 1, 0, 0);
      step(0, 0, 0, 1, 0);
      checkVal("t5_game_still", int'(bus.game), 1);
      checkVal("t5_game_secs10", int'(bus.secsLeft), 10);
      step(1, 0, 0, 0, 0);
      checkVal("t5_game_secs9", int'(bus.secsLeft), 9);

      // Reset on the cycle that would have emitted startGen
      step(0, 0, 0, 0, 1);
      step(0, 1, 0, 0, 0);
      ticks(2);
      step(1, 0, 0, 0, 1);
      checkVal("reset_mid_strobe_startGen", int'(bus.startGen), 0);
      checkVal("reset_mid_strobe_game", int'(bus.game), 0);
      idle(3);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
